// File: rtl/gpio_in_reg_pkg.sv
// gpio_in_reg_pkg
// Shared definitions for the GPIO input register block.
//   - Register address constants for the core bus decode.
//   - gpio_in_addr_e: typed view of the 2-bit register select.
//   - edge_event(): per-bit edge selection (1 = rising, 0 = falling).
package gpio_in_reg_pkg;

  localparam logic [1:0] GPIO_IN_PIN    = 2'd0;
  localparam logic [1:0] GPIO_IN_IE     = 2'd1;
  localparam logic [1:0] GPIO_IN_EDGE   = 2'd2;
  localparam logic [1:0] GPIO_IN_STATUS = 2'd3;

  typedef enum logic [1:0] {
    REG_PIN    = GPIO_IN_PIN,
    REG_IE     = GPIO_IN_IE,
    REG_EDGE   = GPIO_IN_EDGE,
    REG_STATUS = GPIO_IN_STATUS
  } gpio_in_addr_e;

  // Single-bit edge event: rising when sel=1, falling when sel=0.
  function automatic logic edge_event(input logic cur, input logic prev, input logic sel);
    logic rise;
    logic fall;
    rise = cur & ~prev;
    fall = ~cur & prev;
    return sel ? rise : fall;
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce
// One-bit pad input conditioner: two-flop synchroniser followed by a
// persistence counter. The stable output only follows the synchronised
// input after it has differed from stable for DEBOUNCE_CYCLES consecutive
// cycles; any return to the stable value restarts the count.
// Ports:
//   clk       system clock
//   rst_n     synchronous active-low reset
//   pin_in    asynchronous pad input
//   stable_o  debounced value
module gpio_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_in,
  output logic stable_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = pin_in;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/gpio_in_reg.sv
// gpio_in_reg
// Input-direction GPIO register: debounced pin state, selectable edge
// detection, W1C interrupt status and a level interrupt.
// Ports:
//   clk      system clock
//   rst_n    synchronous active-low reset
//   gpio_in  asynchronous pad inputs
//   addr     register select (PIN / IE / EDGE / STATUS)
//   we       single-cycle write strobe
//   wdata    write data
//   rdata    registered read data, one cycle after addr
//   irq      |(int_status & int_enable), built only from flops
module gpio_in_reg
  import gpio_in_reg_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gpio_in,
  input  logic [1:0]       addr,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             irq
);

  logic [WIDTH-1:0] stable;

  logic [WIDTH-1:0] stable_d_q, stable_d_d;
  logic [WIDTH-1:0] int_enable_q, int_enable_d;
  logic [WIDTH-1:0] edge_sel_q, edge_sel_d;
  logic [WIDTH-1:0] int_status_q, int_status_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] w1c_mask;
  gpio_in_addr_e    sel;

  for (genvar i = 0; i < WIDTH; i++) begin : g_deb
    gpio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk      (clk),
      .rst_n    (rst_n),
      .pin_in   (gpio_in[i]),
      .stable_o (stable[i])
    );
  end

  assign sel = gpio_in_addr_e'(addr);

  always_comb begin
    evt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      evt[i] = edge_event(stable[i], stable_d_q[i], edge_sel_q[i]);
    end
  end

  always_comb begin
    stable_d_d   = stable;
    int_enable_d = int_enable_q;
    edge_sel_d   = edge_sel_q;
    w1c_mask     = '0;
    rdata_d      = '0;

    if (we) begin
      case (sel)
        REG_IE:     int_enable_d = wdata;
        REG_EDGE:   edge_sel_d   = wdata;
        REG_STATUS: w1c_mask     = wdata;
        default:    ;
      endcase
    end

    // A new event on the same edge as its W1C keeps the bit set.
    int_status_d = (int_status_q & ~w1c_mask) | evt;

    // Read mux uses pre-write values so a read/write on one edge sees old data.
    case (sel)
      REG_PIN:    rdata_d = stable;
      REG_IE:     rdata_d = int_enable_q;
      REG_EDGE:   rdata_d = edge_sel_q;
      REG_STATUS: rdata_d = int_status_q;
      default:    rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stable_d_q   <= '0;
      int_enable_q <= '0;
      edge_sel_q   <= '0;
      int_status_q <= '0;
      rdata_q      <= '0;
    end else begin
      stable_d_q   <= stable_d_d;
      int_enable_q <= int_enable_d;
      edge_sel_q   <= edge_sel_d;
      int_status_q <= int_status_d;
      rdata_q      <= rdata_d;
    end
  end

  assign rdata = rdata_q;
  assign irq   = |(int_status_q & int_enable_q);

endmodule

// File: tb/tb_gpio_in_reg.sv
module tb_gpio_in_reg;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] gpio_in = '0;
  logic [1:0]   addr = 2'd0;
  logic         we = 1'b0;
  logic [W-1:0] wdata = '0;
  logic [W-1:0] rdata;
  logic         irq;

  int checks = 0;
  int failures = 0;

  gpio_in_reg #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .gpio_in (gpio_in),
    .addr    (addr),
    .we      (we),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // Reference model: pin history of values seen at each clock edge, and
  // architectural register contents.
  logic [W-1:0] samp[$];
  logic [W-1:0] m_stable = '0, m_prev = '0, m_ie = '0, m_edge = '0;
  logic [W-1:0] m_status = '0, m_rdata = '0;
  logic         m_irq = 1'b0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic refill_history();
    samp.delete();
    for (int k = 0; k < D + 2; k++) samp.push_back('0);
  endtask

  // Called right after a posedge with the inputs that edge saw.
  task automatic model_step();
    logic [W-1:0] nst, rise, fall, ev, w1c, nrd, nie, nedge;
    bit all_diff;
    if (!rst_n) begin
      m_stable = '0; m_prev = '0; m_ie = '0; m_edge = '0;
      m_status = '0; m_rdata = '0; m_irq = 1'b0;
      refill_history();
      return;
    end
    samp.push_back(gpio_in);
    if (samp.size() > 16) void'(samp.pop_front());
    // Input reaches the debouncer two edges after capture; stable flips once
    // the last D such values all disagree with it.
    nst = m_stable;
    for (int b = 0; b < W; b++) begin
      all_diff = 1'b1;
      for (int j = 0; j < D; j++)
        if (samp[samp.size() - 3 - j][b] == m_stable[b]) all_diff = 1'b0;
      if (all_diff) nst[b] = ~m_stable[b];
    end
    rise = m_stable & ~m_prev;
    fall = ~m_stable & m_prev;
    ev   = (rise & m_edge) | (fall & ~m_edge);
    case (addr)
      2'd0: nrd = m_stable;
      2'd1: nrd = m_ie;
      2'd2: nrd = m_edge;
      default: nrd = m_status;
    endcase
    w1c   = (we && addr == 2'd3) ? wdata : '0;
    nie   = (we && addr == 2'd1) ? wdata : m_ie;
    nedge = (we && addr == 2'd2) ? wdata : m_edge;
    m_status = (m_status & ~w1c) | ev;
    m_prev   = m_stable;
    m_stable = nst;
    m_ie     = nie;
    m_edge   = nedge;
    m_rdata  = nrd;
    m_irq    = |(m_status & m_ie);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model_rdata", rdata, m_rdata);
    chk("model_irq", {7'b0, irq}, {7'b0, m_irq});
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [W-1:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick();
    we = 1'b0; wdata = '0;
  endtask

  task automatic reg_read(input logic [1:0] a, input string tag, input logic [W-1:0] exp);
    addr = a;
    tick();
    chk(tag, rdata, exp);
  endtask

  initial begin
    // Reset with pins low; every register reads zero.
    rst_n = 1'b0;
    repeat (2) tick();
    chk("reset_irq", {7'b0, irq}, 8'h00);
    rst_n = 1'b1;
    for (int a = 0; a < 4; a++) reg_read(2'(a), "reset_read", 8'h00);
    chk("reset_irq_after", {7'b0, irq}, 8'h00);

    // 3-cycle glitch on pin 3 never reaches PIN or STATUS.
    reg_write(2'd2, 8'hFF);
    gpio_in[3] = 1'b1;
    repeat (3) tick();
    gpio_in[3] = 1'b0;
    repeat (8) tick();
    reg_read(2'd0, "glitch_pin", 8'h00);
    reg_read(2'd3, "glitch_status", 8'h00);

    // IE=01, EDGE=01; latency of a rising edge on pin 0.
    reg_write(2'd1, 8'h01);
    reg_write(2'd2, 8'h01);
    addr = 2'd0;
    gpio_in[0] = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      tick();
      chk("latency_before", rdata, 8'h00);
    end
    tick();
    chk("latency_at_n6", rdata, 8'h01);
    tick();
    chk("latency_after", rdata, 8'h01);
    reg_read(2'd3, "rise_status", 8'h01);
    chk("rise_irq", {7'b0, irq}, 8'h01);
    reg_write(2'd3, 8'h01);
    reg_read(2'd3, "w1c_status", 8'h00);
    chk("w1c_irq", {7'b0, irq}, 8'h00);

    // EDGE=00: pin 2 sets status only on its fall; IE[2]=0 keeps irq low.
    reg_write(2'd2, 8'h00);
    gpio_in[2] = 1'b1;
    repeat (10) tick();
    reg_read(2'd3, "fall_no_rise", 8'h00);
    gpio_in[2] = 1'b0;
    repeat (10) tick();
    reg_read(2'd3, "fall_status", 8'h04);
    chk("fall_irq_masked", {7'b0, irq}, 8'h00);

    // W1C of bits 0 and 2 on the same edge a new rise on pin 0 sets bit 0.
    reg_write(2'd2, 8'h01);
    gpio_in[0] = 1'b0;
    repeat (10) tick();
    reg_read(2'd3, "pre_collision", 8'h04);
    gpio_in[0] = 1'b1;
    tick();
    repeat (5) tick();
    reg_write(2'd3, 8'h05);
    reg_read(2'd3, "collision_status", 8'h01);
    chk("collision_irq", {7'b0, irq}, 8'h01);

    // Reset mid-debounce on pin 5 clears everything at the next edge.
    addr = 2'd1;
    gpio_in[5] = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    chk("midreset_rdata", rdata, 8'h00);
    chk("midreset_irq", {7'b0, irq}, 8'h00);
    rst_n = 1'b1;
    for (int a = 0; a < 4; a++) reg_read(2'(a), "post_reset_read", 8'h00);
    repeat (6) tick();
    reg_read(2'd0, "post_reset_pin", 8'h21);

    // Randomised traffic against the model.
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 7) == 0) gpio_in[b] = ~gpio_in[b];
      addr  = 2'($urandom_range(0, 3));
      we    = ($urandom_range(0, 4) == 0);
      wdata = W'($urandom);
      tick();
    end
    we = 1'b0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
